// File: rtl/tdm_demux_pkg.sv
// Shared types and sizing for the 4-slot TDM demultiplexer.
// TDM_DEMUX_PARITY_EN adds an even-parity fifth slot to every frame.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int SLOTS_DATA = 4;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int SLOTS_FRAME = SLOTS_DATA + 1;
`else
  localparam int SLOTS_FRAME = SLOTS_DATA;
`endif

  localparam int SLOT_W = 3;
  localparam int MISS_W = 3;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_FRAME - 1);

endpackage

// File: rtl/dec_2x4.sv
// 2-to-4 one-hot decoder with enable; drives the shadow-register capture strobes.
module dec_2x4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux_4.sv
// Receiving end of the 4:1 TDM serializer: frame lock, slot capture, lane update.
// Define TDM_DEMUX_PARITY_EN for 5-slot frames carrying even parity in slot 4.
module tdm_demux_4
  import tdm_demux_pkg::*;
#(
  parameter int SYNC_LOSS_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       din,
  input  logic       sync,
  output logic [3:0] O,
  output logic       frame_valid,
  output logic       locked,
  output logic       sync_err,
  output logic       par_err
);

  state_t                  state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [MISS_W-1:0]       miss_q, miss_d, miss_inc;
  logic [SLOTS_DATA-1:0]   shadow_q;
  logic [SLOTS_DATA-1:0]   cap_en;
  logic [SLOTS_DATA-1:0]   frame_bits;
  logic [1:0]              cap_sel;
  logic                    cap_any;
  logic                    load_o;
  logic                    serr_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic                    perr_d;
`endif

  assign miss_inc = miss_q + MISS_W'(1);
  assign locked   = (state_q == LOCKED);

  dec_2x4 u_dec (
    .en  (cap_any),
    .sel (cap_sel),
    .y   (cap_en)
  );

  // Frame as it will look once this edge's capture lands; the last data slot
  // therefore appears directly on O without waiting for the shadow update.
  assign frame_bits = (shadow_q & ~cap_en) | ({SLOTS_DATA{din}} & cap_en);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    miss_d  = miss_q;
    cap_any = 1'b0;
    cap_sel = slot_q[1:0];
    load_o  = 1'b0;
    serr_d  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    perr_d  = 1'b0;
`endif
    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            cap_any = 1'b1;
            cap_sel = 2'd0;
            slot_d  = SLOT_W'(1);
            miss_d  = '0;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (slot_q == '0) begin
            // Flywheel: slot 0 is captured even when the marker is missing.
            cap_any = 1'b1;
            cap_sel = 2'd0;
            slot_d  = SLOT_W'(1);
            if (sync) begin
              miss_d = '0;
            end else if (miss_inc == MISS_W'(SYNC_LOSS_LIMIT)) begin
              state_d = HUNT;
              slot_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end else if (sync) begin
            // Misplaced marker: restart the frame with this slot as slot 0.
            serr_d  = 1'b1;
            cap_any = 1'b1;
            cap_sel = 2'd0;
            slot_d  = SLOT_W'(1);
            miss_d  = '0;
          end else begin
            cap_any = (slot_q < SLOT_W'(SLOTS_DATA));
            if (slot_q == LAST_SLOT) begin
              slot_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
              if (din == ^shadow_q) load_o = 1'b1;
              else                  perr_d = 1'b1;
`else
              load_o = 1'b1;
`endif
            end else begin
              slot_d = slot_q + SLOT_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= '0;
      miss_q      <= '0;
      O           <= 4'b0000;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      miss_q      <= miss_d;
      frame_valid <= load_o;
      sync_err    <= serr_d;
      if (load_o) O <= frame_bits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      for (int k = 0; k < SLOTS_DATA; k++) begin
        if (cap_en[k]) shadow_q[k] <= din;
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= perr_d;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
